// File: rtl/alu_pkg.sv
// alu_pkg: opcode bit indices, FSM states and select validation shared by alu_seq
package alu_pkg;
  localparam int SEL_ADD = 0;
  localparam int SEL_SUB = 1;
  localparam int SEL_AND = 2;
  localparam int SEL_OR  = 3;
  localparam int SEL_XOR = 4;
  localparam int SEL_NOT = 5;
  localparam int SEL_SHL = 6;
  localparam int SEL_MUL = 7;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic onehot_ok(input logic [7:0] sel);
    return sel != 8'd0 && (sel & (sel - 8'd1)) == 8'd0;
  endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-cycle shift-add multiplier, one multiplier bit per cycle, LSB first
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  // product includes the final iteration so the caller can register it on the done edge
  always_comb begin
    product = acc_q + (mplier_q[0] ? mcand_q : '0);
    done = run_q && cnt_q == CW'(WIDTH - 1);
    mcand_d = start ? {{WIDTH{1'b0}}, a} : run_q ? mcand_q << 1 : mcand_q;
    mplier_d = start ? b : run_q ? mplier_q >> 1 : mplier_q;
    acc_d = start ? '0 : run_q ? product : acc_q;
    cnt_d = start ? '0 : run_q ? cnt_q + CW'(1) : cnt_q;
    run_d = start || (run_q && !done);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked one-hot-select ALU with registered result, flags and sequential multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [7:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero,
  output logic             err
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, alu_res;
  logic carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic legal, alu_carry, accept, mul_start, mul_done;
  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH-1:0] product;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_start),
    .a(op1),
    .b(op2),
    .done(mul_done),
    .product(product)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign res = res_q;
  assign carry = carry_q;
  assign zero = zero_q;
  assign err = err_q;
  always_comb begin
    legal = onehot_ok(select);
    sum = {1'b0, op1} + {1'b0, op2};
    diff = {1'b0, op1} - {1'b0, op2};
    alu_res = !legal ? '0 :
              select[SEL_ADD] ? sum[WIDTH-1:0] :
              select[SEL_SUB] ? diff[WIDTH-1:0] :
              select[SEL_AND] ? op1 & op2 :
              select[SEL_OR]  ? op1 | op2 :
              select[SEL_XOR] ? op1 ^ op2 :
              select[SEL_NOT] ? ~op1 :
              select[SEL_SHL] ? {op1[WIDTH-2:0], 1'b0} : '0;
    alu_carry = legal && (select[SEL_ADD] ? sum[WIDTH] :
                          select[SEL_SUB] ? diff[WIDTH] :
                          select[SEL_SHL] && op1[WIDTH-1]);
    accept = in_valid && in_ready;
    mul_start = accept && legal && select[SEL_MUL];
    state_d = state_q;
    res_d = res_q;
    carry_d = carry_q;
    zero_d = zero_q;
    err_d = err_q;
    if (mul_start) begin
      state_d = BUSY;
    end else if (accept) begin
      state_d = DONE;
      res_d = alu_res;
      carry_d = alu_carry;
      zero_d = alu_res == '0;
      err_d = !legal;
    end else if (state_q == BUSY && mul_done) begin
      state_d = DONE;
      res_d = product[WIDTH-1:0];
      carry_d = |product[2*WIDTH-1:WIDTH];
      zero_d = product[WIDTH-1:0] == '0;
      err_d = 1'b0;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, carry, zero, err;
  logic [W-1:0] op1 = '0, op2 = '0, res;
  logic [7:0] select = '0;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .select(select), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .carry(carry), .zero(zero), .err(err)
  );
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] s,
                                output logic [W-1:0] r, output logic c, output logic z, output logic e);
    longint ua = longint'(a), ub = longint'(b), m = longint'(1) << W, x = 0;
    e = $countones(s) != 1;
    c = 1'b0;
    if (!e) begin
      case (s)
        8'h01: begin x = ua + ub; c = x >= m; end
        8'h02: begin x = ua - ub + m; c = ua < ub; end
        8'h04: x = longint'(a & b);
        8'h08: x = longint'(a | b);
        8'h10: x = longint'(a ^ b);
        8'h20: x = m - 1 - ua;
        8'h40: begin x = ua * 2; c = ua >= m / 2; end
        default: begin x = ua * ub; c = x >= m; end
      endcase
    end
    r = W'(x % m);
    z = r == '0;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] s,
                        output int lat, output int ir_bad, output logic [W-1:0] r,
                        output logic c, output logic z, output logic e, output int acc_cyc);
    int n = 0;
    op1 = a; op2 = b; select = s; in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0; op1 = W'($urandom); op2 = W'($urandom); select = 8'($urandom);
    lat = 1; ir_bad = 0;
    while (!out_valid && lat < 4 * W) begin
      if (in_ready) ir_bad++;
      tick();
      lat++;
    end
    r = res; c = carry; z = zero; e = err;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, in_ready, res, carry, zero, err} !== {1'b0, 1'b1, {W{1'b0}}, 3'b000}) begin
      failures++;
      $display("FAIL reset_state: got ov=%b ir=%b res=%h c=%b z=%b e=%b expected ov=0 ir=1 res=00 c=0 z=0 e=0",
               out_valid, in_ready, res, carry, zero, err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_idle: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
    end
  endtask
  task automatic test_fixed_ops();
    logic [7:0] sels [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    logic [7:0] exp_r [7] = '{8'h77, 8'hDF, 8'h88, 8'hEF, 8'h67, 8'h54, 8'h56};
    logic exp_c [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, irb, ac;
    logic [W-1:0] r;
    logic c, z, e;
    for (int i = 0; i < 7; i++) begin
      run_op(8'hAB, 8'hCC, sels[i], lat, irb, r, c, z, e, ac);
      checks++;
      if ({r, c, e, lat} !== {exp_r[i], exp_c[i], 1'b0, 32'sd1}) begin
        failures++;
        $display("FAIL fixed_op sel=%h: got res=%h c=%b e=%b lat=%0d expected res=%h c=%b e=0 lat=1",
                 sels[i], r, c, e, lat, exp_r[i], exp_c[i]);
      end
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        failures++;
        $display("FAIL fixed_op_release sel=%h: got ov=%b ir=%b expected ov=0 ir=1", sels[i], out_valid, in_ready);
      end
    end
  endtask
  task automatic test_mul();
    int lat, irb, ac;
    logic [W-1:0] r;
    logic c, z, e;
    run_op(8'hAB, 8'hCC, 8'h80, lat, irb, r, c, z, e, ac);
    checks++;
    if ({r, c, z, e, lat, irb, in_ready} !== {8'h44, 3'b100, 32'sd9, 32'sd0, 1'b0}) begin
      failures++;
      $display("FAIL mul_ab_cc: got res=%h c=%b z=%b e=%b lat=%0d ir_high=%0d ir=%b expected res=44 c=1 z=0 e=0 lat=9 ir_high=0 ir=0",
               r, c, z, e, lat, irb, in_ready);
    end
    tick();
    run_op(8'h0F, 8'h03, 8'h80, lat, irb, r, c, z, e, ac);
    checks++;
    if ({r, c, z, lat} !== {8'h2D, 2'b00, 32'sd9}) begin
      failures++;
      $display("FAIL mul_0f_03: got res=%h c=%b z=%b lat=%0d expected res=2d c=0 z=0 lat=9", r, c, z, lat);
    end
    tick();
  endtask
  task automatic test_illegal();
    logic [7:0] sels [2] = '{8'h00, 8'h03};
    int lat, irb, ac;
    logic [W-1:0] r;
    logic c, z, e;
    for (int i = 0; i < 2; i++) begin
      run_op(8'h5A, 8'h33, sels[i], lat, irb, r, c, z, e, ac);
      checks++;
      if ({r, c, z, e, lat} !== {8'h00, 3'b011, 32'sd1}) begin
        failures++;
        $display("FAIL illegal sel=%h: got res=%h c=%b z=%b e=%b lat=%0d expected res=00 c=0 z=1 e=1 lat=1",
                 sels[i], r, c, z, e, lat);
      end
      tick();
    end
    run_op(8'h80, 8'h80, 8'h01, lat, irb, r, c, z, e, ac);
    checks++;
    if ({r, c, z, e} !== {8'h00, 3'b110}) begin
      failures++;
      $display("FAIL add_wrap_zero: got res=%h c=%b z=%b e=%b expected res=00 c=1 z=1 e=0", r, c, z, e);
    end
    tick();
  endtask
  task automatic test_backpressure();
    int lat, irb, ac;
    logic [W-1:0] r;
    logic c, z, e;
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 8'h01, lat, irb, r, c, z, e, ac);
    checks++;
    if ({r, lat} !== {8'h46, 32'sd1}) begin
      failures++;
      $display("FAIL bp_result: got res=%h lat=%0d expected res=46 lat=1", r, lat);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op1 = W'($urandom); op2 = W'($urandom); select = 8'h01;
      tick();
      checks++;
      if ({out_valid, in_ready, res, carry, zero, err} !== {2'b10, 8'h46, 3'b000}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b res=%h c=%b z=%b e=%b expected ov=1 ir=0 res=46 c=0 z=0 e=0",
                 i, out_valid, in_ready, res, carry, zero, err);
      end
    end
    op1 = 8'h05; op2 = 8'h03; select = 8'h02;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, res, carry} !== {2'b10, 8'h02, 1'b0}) begin
      failures++;
      $display("FAIL bp_next_op: got ov=%b ir=%b res=%h c=%b expected ov=1 ir=0 res=02 c=0",
               out_valid, in_ready, res, carry);
    end
    tick();
  endtask
  task automatic test_reset_mid_mul();
    int lat, irb, ac, pulses = 0;
    logic [W-1:0] r;
    logic c, z, e;
    op1 = 8'hFF; op2 = 8'hFF; select = 8'h80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, res, carry, zero, err} !== {2'b01, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL mid_mul_reset: got ov=%b ir=%b res=%h c=%b z=%b e=%b expected ov=0 ir=1 res=00 c=0 z=0 e=0",
               out_valid, in_ready, res, carry, zero, err);
    end
    for (int i = 0; i < 2 * W; i++) begin
      if (out_valid) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL mid_mul_no_result: got %0d out_valid cycles expected 0", pulses);
    end
    run_op(8'h01, 8'h01, 8'h01, lat, irb, r, c, z, e, ac);
    checks++;
    if ({r, c, z, e, lat} !== {8'h02, 3'b000, 32'sd1}) begin
      failures++;
      $display("FAIL post_reset_add: got res=%h c=%b z=%b e=%b lat=%0d expected res=02 c=0 z=0 e=0 lat=1",
               r, c, z, e, lat);
    end
    tick();
  endtask
  task automatic test_back_to_back();
    int lat, irb, ac, prev_ac = 0, exp_lat;
    logic prev_short = 1'b0;
    logic [W-1:0] a, b, r, er;
    logic [7:0] s;
    logic c, z, e, ec, ez, ee;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom); b = W'($urandom);
      s = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      if (i % 10 == 3) a = '0;
      model(a, b, s, er, ec, ez, ee);
      exp_lat = (s == 8'h80) ? W + 1 : 1;
      run_op(a, b, s, lat, irb, r, c, z, e, ac);
      checks++;
      if ({r, c, z, e, lat} !== {er, ec, ez, ee, exp_lat}) begin
        failures++;
        $display("FAIL random op%0d a=%h b=%h sel=%h: got res=%h c=%b z=%b e=%b lat=%0d expected res=%h c=%b z=%b e=%b lat=%0d",
                 i, a, b, s, r, c, z, e, lat, er, ec, ez, ee, exp_lat);
      end
      if (i > 0 && prev_short) begin
        checks++;
        if (ac - prev_ac !== 2) begin
          failures++;
          $display("FAIL throughput op%0d: got %0d cycles between accepts expected 2", i, ac - prev_ac);
        end
      end
      prev_ac = ac;
      prev_short = exp_lat == 1;
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_fixed_ops();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
